// File: rtl/serial_word_rx.sv
// LSB-first serial word receiver with output FIFO and sticky status flags.
// Optional even-parity bit per word: define SERIAL_WORD_RX_PARITY_EN.
module serial_word_rx #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       rx_bit,
  input  logic                       rx_valid,
  input  logic                       rx_clear,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     fill,
  output logic                       busy,
  output logic                       ovf,
  output logic                       par_err,
  input  logic                       ovf_clr
);

  localparam int CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNTW = $clog2(DEPTH) + 1;

`ifdef SERIAL_WORD_RX_PARITY_EN
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PAR} state_t;
`else
  typedef enum logic [0:0] {S_IDLE, S_SHIFT} state_t;
`endif

  state_t           state_q, state_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             par_err_q, par_err_d;

  logic push, par_bad, pop, full, do_push;

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    push      = 1'b0;
    par_bad   = 1'b0;
    if (rx_clear) begin
      state_d   = S_IDLE;
      bit_cnt_d = '0;
    end else if (rx_valid) begin
`ifdef SERIAL_WORD_RX_PARITY_EN
      if (state_q == S_PAR) begin
        state_d = S_IDLE;
        // Even parity: data plus parity bit has an even number of ones.
        if ((^shreg_q) == rx_bit) push = 1'b1;
        else                      par_bad = 1'b1;
      end else
`endif
      begin
        shreg_d[bit_cnt_q] = rx_bit;
        if (bit_cnt_q == CW'(WIDTH - 1)) begin
          bit_cnt_d = '0;
`ifdef SERIAL_WORD_RX_PARITY_EN
          state_d = S_PAR;
`else
          state_d = S_IDLE;
          push    = 1'b1;
`endif
        end else begin
          bit_cnt_d = bit_cnt_q + CW'(1);
          state_d   = S_SHIFT;
        end
      end
    end
  end

  assign pop     = (count_q != '0) && out_ready;
  assign full    = (count_q == CNTW'(DEPTH));
  // A full FIFO still accepts a word when the head leaves the same cycle.
  assign do_push = push && (!full || pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = shreg_d;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + CNTW'(do_push) - CNTW'(pop);
  end

  always_comb begin
    ovf_d     = ovf_q;
    par_err_d = par_err_q;
    if (ovf_clr) begin
      ovf_d     = 1'b0;
      par_err_d = 1'b0;
    end
    if (push && full && !pop) ovf_d = 1'b1;
    if (par_bad)              par_err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_q     <= 1'b0;
      par_err_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_q     <= ovf_d;
      par_err_q <= par_err_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign out_data  = mem_q[rd_ptr_q];
  assign out_valid = (count_q != '0);
  assign fill      = count_q;
  assign busy      = (bit_cnt_q != '0);
  assign ovf       = ovf_q;
`ifdef SERIAL_WORD_RX_PARITY_EN
  assign par_err   = par_err_q;
`else
  assign par_err   = 1'b0;
`endif

endmodule

// File: tb/tb_serial_word_rx.sv
// Directed bench for serial_word_rx (default build, WIDTH=4, DEPTH=4).
module tb_serial_word_rx;

  logic       clk = 1'b0;
  logic       reset, rx_bit, rx_valid, rx_clear, out_ready, ovf_clr;
  logic [3:0] out_data;
  logic       out_valid, busy, ovf, par_err;
  logic [2:0] fill;

  int vecs = 0;
  int errs = 0;

  serial_word_rx #(.WIDTH(4), .DEPTH(4)) dut (
    .clk(clk), .reset(reset), .rx_bit(rx_bit), .rx_valid(rx_valid),
    .rx_clear(rx_clear), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .fill(fill), .busy(busy), .ovf(ovf),
    .par_err(par_err), .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    rx_valid = 1'b1;
    rx_bit   = b;
    tick();
    rx_valid = 1'b0;
    rx_bit   = 1'b0;
  endtask

  task automatic send_word(input logic [3:0] w);
    for (int i = 0; i < 4; i++) send_bit(w[i]);
  endtask

  initial begin
    reset = 1'b1; rx_bit = 1'b0; rx_valid = 1'b0; rx_clear = 1'b0;
    out_ready = 1'b0; ovf_clr = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_fill", fill, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_par", par_err, 0);

    // 1,0,1,1 -> 4'hD, consumer ready
    out_ready = 1'b1;
    send_bit(1'b1);
    chk("w1_busy", busy, 1);
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    chk("w1_valid", out_valid, 1);
    chk("w1_data", out_data, 4'hD);
    chk("w1_fill", fill, 1);
    chk("w1_busy_end", busy, 0);
    tick();
    chk("w1_pop_fill", fill, 0);
    chk("w1_pop_valid", out_valid, 0);
    out_ready = 1'b0;

    // same word with gaps of 0..3 idle cycles
    send_bit(1'b1);
    chk("gap_busy_b0", busy, 1);
    tick();
    chk("gap_busy_g1", busy, 1);
    send_bit(1'b0);
    tick(); tick();
    chk("gap_busy_g2", busy, 1);
    send_bit(1'b1);
    tick(); tick(); tick();
    chk("gap_busy_g3", busy, 1);
    chk("gap_novalid", out_valid, 0);
    send_bit(1'b1);
    chk("gap_busy_end", busy, 0);
    chk("gap_data", out_data, 4'hD);
    chk("gap_fill", fill, 1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    chk("gap_drain", fill, 0);

    // partial word aborted by rx_clear
    send_bit(1'b1); send_bit(1'b1);
    rx_clear = 1'b1; rx_valid = 1'b1; rx_bit = 1'b1;
    tick();
    rx_clear = 1'b0; rx_valid = 1'b0; rx_bit = 1'b0;
    chk("clr_busy", busy, 0);
    chk("clr_fill0", fill, 0);
    send_word(4'h6);
    chk("clr_data", out_data, 4'h6);
    chk("clr_fill", fill, 1);
    chk("clr_ovf", ovf, 0);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // overflow on fifth word with consumer stalled
    for (int k = 1; k <= 4; k++) send_word(4'(k));
    chk("ovf_fill4", fill, 4);
    chk("ovf_pre", ovf, 0);
    chk("ovf_hold", out_data, 4'h1);
    send_word(4'h5);
    chk("ovf_fill5", fill, 4);
    chk("ovf_set", ovf, 1);
    out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      chk($sformatf("ovf_pop%0d", k), out_data, 4'(k));
      tick();
    end
    out_ready = 1'b0;
    chk("ovf_empty", fill, 0);
    chk("ovf_sticky", ovf, 1);
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    chk("ovf_clr", ovf, 0);

    // word completes on the same edge as a pop from a full FIFO
    for (int k = 1; k <= 4; k++) send_word(4'(k));
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b0);
    out_ready = 1'b1;
    send_bit(1'b1);
    out_ready = 1'b0;
    chk("fp_fill", fill, 4);
    chk("fp_ovf", ovf, 0);
    chk("fp_head", out_data, 4'h2);

    // set beats a simultaneous ovf_clr
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    ovf_clr = 1'b1;
    send_bit(1'b1);
    ovf_clr = 1'b0;
    chk("setwin_ovf", ovf, 1);
    out_ready = 1'b1;
    chk("fp_pop2", out_data, 4'h2); tick();
    chk("fp_pop3", out_data, 4'h3); tick();
    chk("fp_pop4", out_data, 4'h4); tick();
    chk("fp_pop9", out_data, 4'h9); tick();
    out_ready = 1'b0;
    chk("fp_empty", fill, 0);

    // reset mid-word, then a clean word
    send_word(4'h7);
    send_bit(1'b1); send_bit(1'b0);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("rr_fill", fill, 0);
    chk("rr_busy", busy, 0);
    chk("rr_valid", out_valid, 0);
    chk("rr_ovf", ovf, 0);
    send_word(4'hA);
    chk("rr_data", out_data, 4'hA);
    chk("rr_fill1", fill, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
